tetris_key_ctrl: RTL and testbench

Keyboard front-end controller for the Tetris game logic. It does the following:
- Replaces per-key scanner instances with one shared 50 Hz-style sampling timebase across all keys.
- Detects presses and generates auto-repeat events for held keys.
- Arbitrates simultaneous key events round-robin into a small event FIFO.
- Presents the FIFO to the game FSM over a valid/ready handshake.

---
 rtl/tetris_key_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_tetris_key_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_key_ctrl.sv
`timescale 1ns/1ps
// tetris_key_ctrl: shared scan timebase, press/auto-repeat detection, round-robin arbiter, event FIFO.
// Latency: key sampled at scan tick edge E0, pushed at E1, evt_valid high the cycle after E1.
// Backpressure: evt_valid/evt_ready; a full FIFO holds pend bits, loss only on a pending collision.
//
// Ports: clk, rst_n (async, active-low); key_n[N_KEYS] raw active-low keys;
//   evt_valid/evt_ready handshake with evt_code (key index) and evt_repeat (auto-repeat flag);
//   overflow sticky event-loss flag, cleared by clr_overflow (a new loss wins).
// Optional feature: define KEY_AUTOREPEAT_EN to enable hold counters and auto-repeat events.
module tetris_key_ctrl #(
  parameter int N_KEYS       = 4,
  parameter int SCAN_DIV     = 200,
  parameter int REPEAT_DELAY = 25,
  parameter int REPEAT_RATE  = 5,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_KEYS-1:0]         key_n,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(N_KEYS)-1:0] evt_code,
  output logic                      evt_repeat,
  output logic                      overflow,
  input  logic                      clr_overflow
);

  localparam int CW = $clog2(N_KEYS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef KEY_AUTOREPEAT_EN
  localparam int EW = CW + 1;
`else
  localparam int EW = CW;
`endif

  // Shared scan timebase
  logic [SW-1:0] scan_cnt;
  logic          tick;

  assign tick = (scan_cnt == SW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    scan_cnt <= '0;
    else if (tick) scan_cnt <= '0;
    else           scan_cnt <= scan_cnt + 1'b1;
  end

  // Sample register. 'armed' marks keys seen released at least once since
  // reset, so a key held through reset does not count as a fresh press.
  logic [N_KEYS-1:0] sample, armed;
  logic [N_KEYS-1:0] press_evt, rep_evt, new_evt, collide, grant_oh, pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= '1;
      armed  <= '0;
    end else if (tick) begin
      sample <= key_n;
      armed  <= armed | key_n;
    end
  end

  assign press_evt = {N_KEYS{tick}} & armed & sample & ~key_n;

`ifdef KEY_AUTOREPEAT_EN
  // Counter value that fires a repeat on the next tick, and the reload that
  // spaces later repeats REPEAT_RATE ticks apart (assumes RATE <= DELAY).
  localparam logic [7:0] DELAY_M1 = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0] RELOAD   = 8'(REPEAT_DELAY - REPEAT_RATE);

  logic [7:0]        hold_cnt [N_KEYS];
  logic [N_KEYS-1:0] rep_flag;

  always_comb begin
    rep_evt = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      rep_evt[i] = tick & armed[i] & ~sample[i] & ~key_n[i] & (hold_cnt[i] == DELAY_M1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEYS; i++) hold_cnt[i] <= '0;
      rep_flag <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (tick) begin
          if (key_n[i] || press_evt[i]) hold_cnt[i] <= '0;
          else if (rep_evt[i])          hold_cnt[i] <= RELOAD;
          else                          hold_cnt[i] <= hold_cnt[i] + 8'd1;
        end
        // A dropped event leaves the pending event's flag untouched.
        if (new_evt[i] && !collide[i]) rep_flag[i] <= rep_evt[i];
      end
    end
  end
`else
  assign rep_evt = '0;
`endif

  assign new_evt = press_evt | rep_evt;
  // Granting key i in the same cycle frees its slot, so that is not a collision.
  assign collide = new_evt & pend & ~grant_oh;

  // Round-robin arbiter: lowest pending index >= rr, else lowest overall.
  logic [CW-1:0] rr, gidx, hi_idx, lo_idx;
  logic          any_hi, any_pend, gnt, can_push, pop, full;
  logic [AW:0]   count;

  always_comb begin
    any_hi   = 1'b0;
    any_pend = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        any_pend = 1'b1;
        lo_idx   = CW'(i);
      end
      if (pend[i] && (CW'(i) >= rr)) begin
        any_hi = 1'b1;
        hi_idx = CW'(i);
      end
    end
    gidx     = any_hi ? hi_idx : lo_idx;
    gnt      = any_pend & can_push;
    grant_oh = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      grant_oh[i] = gnt && (gidx == CW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      rr       <= '0;
      overflow <= 1'b0;
    end else begin
      pend <= (pend & ~grant_oh) | new_evt;
      if (gnt) rr <= (gidx == CW'(N_KEYS - 1)) ? '0 : gidx + 1'b1;
      if (|collide)          overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // Event FIFO; a push is accepted while full if the head pops in the same cycle.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] push_dat;
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign evt_valid = (count != '0);
  assign pop       = evt_valid & evt_ready;
  assign can_push  = !full || pop;

`ifdef KEY_AUTOREPEAT_EN
  assign push_dat   = {rep_flag[gidx], gidx};
  assign evt_repeat = mem[rd_ptr][CW];
`else
  assign push_dat   = gidx;
  assign evt_repeat = 1'b0;
`endif
  assign evt_code = mem[rd_ptr][CW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (gnt) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({gnt, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_key_ctrl.sv
`timescale 1ns/1ps
// tb_tetris_key_ctrl: directed scenarios for tetris_key_ctrl with hand-computed expectations.
// Runs with N_KEYS=4, SCAN_DIV=8, REPEAT_DELAY=3, REPEAT_RATE=2, FIFO_DEPTH=2.
// Auto-repeat or press-only scenario is selected by KEY_AUTOREPEAT_EN.
module tb_tetris_key_ctrl;

  localparam int SD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_n = 4'b1111;
  logic       evt_ready = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_repeat;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  int phase;

  int         ev_n;
  logic [1:0] ev_code [16];
  logic       ev_rep [16];
  int         ev_tick [16];

  tetris_key_ctrl #(
    .N_KEYS(4), .SCAN_DIV(SD), .REPEAT_DELAY(3), .REPEAT_RATE(2), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_repeat(evt_repeat), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  // Bench-side view of the scan timebase: phase 0 follows a tick edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= 0;
    else        phase <= (phase == SD - 1) ? 0 : phase + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Return 1 ns after the next scan tick edge.
  task automatic to_tick();
    do begin
      @(posedge clk);
      #1;
    end while (phase != 0);
  endtask

  // Wait (bounded) for one event and pop it.
  task automatic get_evt(output logic got, output logic [1:0] code, output logic rep, input int budget);
    got  = 1'b0;
    code = 2'd0;
    rep  = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (evt_valid) begin
        got  = 1'b1;
        code = evt_code;
        rep  = evt_repeat;
        @(posedge clk);
        #1;
      end
    end
    evt_ready = 1'b0;
  endtask

  // Record events (evt_ready held by caller) until tick index last_tick;
  // tick 0 is the first tick edge after the call. Applies rel_val after tick release_after.
  task automatic monitor(input int last_tick, input int release_after, input logic [3:0] rel_val);
    int tick_no;
    tick_no = -2;
    ev_n = 0;
    while (tick_no < last_tick) begin
      @(negedge clk);
      if (phase == 0) begin
        tick_no++;
        if (tick_no == release_after) key_n = rel_val;
      end
      if (evt_valid && ev_n < 16) begin
        ev_code[ev_n] = evt_code;
        ev_rep[ev_n]  = evt_repeat;
        ev_tick[ev_n] = tick_no;
        ev_n++;
      end
    end
  endtask

  task automatic test_reset();
    key_n = 4'b1111; evt_ready = 1'b0; clr_overflow = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", evt_valid); end
    checks++; if (evt_code !== 2'd0) begin failures++; $display("FAIL rst_code: got %0d want 0", evt_code); end
    checks++; if (evt_repeat !== 1'b0) begin failures++; $display("FAIL rst_repeat: got %b want 0", evt_repeat); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    do_reset();
    to_tick(); to_tick();
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL idle_valid: got %b want 0", evt_valid); end
  endtask

  task automatic test_single_press();
    logic got; logic [1:0] c; logic r;
    do_reset(); to_tick();
    key_n = 4'b1011;
    to_tick();
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL single_e0_valid: got %b want 0", evt_valid); end
    @(posedge clk); #1;
    checks++; if (evt_valid !== 1'b1) begin failures++; $display("FAIL single_e1_valid: got %b want 1", evt_valid); end
    checks++; if (evt_code !== 2'd2 || evt_repeat !== 1'b0) begin failures++;
      $display("FAIL single_head: got code %0d rep %b want code 2 rep 0", evt_code, evt_repeat); end
    key_n = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (evt_valid !== 1'b1 || evt_code !== 2'd2) begin failures++;
      $display("FAIL single_stall_hold: got valid %b code %0d want valid 1 code 2", evt_valid, evt_code); end
    get_evt(got, c, r, 40);
    checks++; if (!got || c !== 2'd2 || r !== 1'b0) begin failures++;
      $display("FAIL single_pop: got ok %b code %0d rep %b want ok 1 code 2 rep 0", got, c, r); end
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL single_empty: got %b want 0", evt_valid); end
    to_tick(); to_tick();
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL single_only_one: got valid %b want 0", evt_valid); end
  endtask

  task automatic test_simultaneous();
    logic got; logic [1:0] c; logic r;
    logic [1:0] exp3 [3];
    logic [1:0] exp2 [2];
    exp3[0] = 2'd1; exp3[1] = 2'd3; exp3[2] = 2'd0;
    exp2[0] = 2'd1; exp2[1] = 2'd0;
    do_reset(); to_tick();
    key_n = 4'b1110; to_tick(); key_n = 4'b1111;
    get_evt(got, c, r, 40);
    checks++; if (!got || c !== 2'd0) begin failures++; $display("FAIL simul_prime: got ok %b code %0d want ok 1 code 0", got, c); end
    to_tick();
    key_n = 4'b0100; to_tick(); key_n = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      get_evt(got, c, r, 40);
      checks++; if (!got || c !== exp3[k] || r !== 1'b0) begin failures++;
        $display("FAIL simul_order%0d: got ok %b code %0d rep %b want ok 1 code %0d rep 0", k, got, c, r, exp3[k]); end
    end
    to_tick();
    key_n = 4'b1100; to_tick(); key_n = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      get_evt(got, c, r, 40);
      checks++; if (!got || c !== exp2[k]) begin failures++;
        $display("FAIL simul_rr%0d: got ok %b code %0d want ok 1 code %0d", k, got, c, exp2[k]); end
    end
    to_tick();
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL simul_drained: got %b want 0", evt_valid); end
  endtask

`ifdef KEY_AUTOREPEAT_EN
  task automatic test_autorepeat();
    logic       exp_rep [5];
    int         exp_tick [5];
    exp_rep[0] = 1'b0; exp_tick[0] = 0;
    exp_rep[1] = 1'b1; exp_tick[1] = 3;
    exp_rep[2] = 1'b1; exp_tick[2] = 5;
    exp_rep[3] = 1'b1; exp_tick[3] = 7;
    exp_rep[4] = 1'b1; exp_tick[4] = 9;
    do_reset(); to_tick();
    evt_ready = 1'b1;
    key_n = 4'b1101;
    monitor(14, 9, 4'b1111);
    evt_ready = 1'b0;
    checks++; if (ev_n != 5) begin failures++; $display("FAIL rep_count: got %0d events want 5", ev_n); end
    for (int k = 0; k < 5 && k < ev_n; k++) begin
      checks++; if (ev_code[k] !== 2'd1 || ev_rep[k] !== exp_rep[k] || ev_tick[k] != exp_tick[k]) begin failures++;
        $display("FAIL rep_evt%0d: got code %0d rep %b tick %0d want code 1 rep %b tick %0d",
                 k, ev_code[k], ev_rep[k], ev_tick[k], exp_rep[k], exp_tick[k]); end
    end
  endtask
`else
  task automatic test_no_repeat();
    do_reset(); to_tick();
    evt_ready = 1'b1;
    key_n = 4'b0111;
    monitor(43, 39, 4'b1111);
    evt_ready = 1'b0;
    checks++; if (ev_n != 1) begin failures++; $display("FAIL norep_count: got %0d events want 1", ev_n); end
    checks++; if (ev_n < 1 || ev_code[0] !== 2'd3 || ev_rep[0] !== 1'b0 || ev_tick[0] != 0) begin failures++;
      $display("FAIL norep_evt: got n %0d code %0d rep %b tick %0d want code 3 rep 0 tick 0", ev_n, ev_code[0], ev_rep[0], ev_tick[0]); end
  endtask
`endif

  task automatic test_backpressure();
    logic got; logic [1:0] c; logic r;
    do_reset(); to_tick();
    evt_ready = 1'b0;
    key_n = 4'b1000; to_tick(); key_n = 4'b1111;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (evt_valid !== 1'b1 || evt_code !== 2'd0) begin failures++;
      $display("FAIL bp_head: got valid %b code %0d want valid 1 code 0", evt_valid, evt_code); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL bp_no_loss_full: got %b want 0", overflow); end
    to_tick();
    key_n = 4'b1011; clr_overflow = 1'b1;
    to_tick();
    clr_overflow = 1'b0; key_n = 4'b1111;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_ovf_set_over_clr: got %b want 1", overflow); end
    for (int k = 0; k < 3; k++) begin
      get_evt(got, c, r, 40);
      checks++; if (!got || c !== 2'(k) || r !== 1'b0) begin failures++;
        $display("FAIL bp_drain%0d: got ok %b code %0d rep %b want ok 1 code %0d rep 0", k, got, c, r, k); end
    end
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL bp_dropped: got valid %b want 0", evt_valid); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_ovf_sticky: got %b want 1", overflow); end
    clr_overflow = 1'b1;
    @(posedge clk); #1;
    clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL bp_ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_reset_midstream();
    logic got; logic [1:0] c; logic r;
    do_reset(); to_tick();
    evt_ready = 1'b0;
    key_n = 4'b1000; to_tick(); key_n = 4'b1110;
    to_tick(); key_n = 4'b1010;
    to_tick(); key_n = 4'b1110;
    checks++; if (evt_valid !== 1'b1 || overflow !== 1'b1) begin failures++;
      $display("FAIL mid_pre: got valid %b ovf %b want valid 1 ovf 1", evt_valid, overflow); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (evt_valid !== 1'b0 || overflow !== 1'b0) begin failures++;
      $display("FAIL mid_async_clear: got valid %b ovf %b want valid 0 ovf 0", evt_valid, overflow); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    monitor(3, 1000, 4'b1110);
    evt_ready = 1'b0;
    checks++; if (ev_n != 0) begin failures++; $display("FAIL mid_held_no_press: got %0d events want 0", ev_n); end
    key_n = 4'b1111; to_tick();
    key_n = 4'b1110; to_tick(); key_n = 4'b1111;
    get_evt(got, c, r, 40);
    checks++; if (!got || c !== 2'd0 || r !== 1'b0) begin failures++;
      $display("FAIL mid_repress: got ok %b code %0d rep %b want ok 1 code 0 rep 0", got, c, r); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_simultaneous();
`ifdef KEY_AUTOREPEAT_EN
    test_autorepeat();
`else
    test_no_repeat();
`endif
    test_backpressure();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
